// File: rtl/idu_alu_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for idu_alu_decode.
// The slave modport is the decoder's view; the master modport drives it.
interface idu_alu_decode_if #(
    parameter int XLEN  = 32,
    parameter int CTL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [CTL_W-1:0] alu_ctl;
    logic [1:0]       src_a_sel;
    logic [1:0]       src_b_sel;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             wen;
    logic             is_branch;
    logic             illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, alu_ctl, src_a_sel, src_b_sel,
               imm, rs1, rs2, rd, wen, is_branch, illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, alu_ctl, src_a_sel, src_b_sel,
               imm, rs1, rs2, rd, wen, is_branch, illegal
    );
endinterface

// File: rtl/idu_alu_decode.sv
// RV32I decode stage: ALU control, operand selects and immediate behind a one-entry
// valid/ready register. Optional perf counters are enabled with `define IDU_PERF_CNT_EN.
module idu_alu_decode #(
    parameter int XLEN  = 32,
    parameter int CTL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    idu_alu_decode_if.slave   bus
`ifdef IDU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_decoded,
    output logic [31:0]       perf_illegal
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [CTL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTL_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [CTL_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [CTL_W-1:0] ALU_SLTU = 4'b0011;

    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [CTL_W-1:0] alu_ctl;
        logic [1:0]       src_a_sel;
        logic [1:0]       src_b_sel;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             wen;
        logic             is_branch;
        logic             illegal;
    } bundle_t;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = XLEN'(signed'({inst[31:12], 12'b0}));
    assign imm_j  = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = XLEN'(inst[24:20]);

    bundle_t dec;
    logic    legal;
    logic    writes_rd;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        legal      = 1'b1;
        writes_rd  = 1'b0;

        case (opcode)
            OPC_OP: begin
                legal       = (funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.alu_ctl = {funct7[5], funct3};
                writes_rd   = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_ctl   = {(funct3 == 3'b101) & funct7[5], funct3};
                dec.src_b_sel = SRC_B_IMM;
                writes_rd     = 1'b1;
                if (funct3 == 3'b001) begin
                    legal   = (funct7 == 7'h00);
                    dec.imm = imm_sh;
                end else if (funct3 == 3'b101) begin
                    legal   = (funct7 == 7'h00) || (funct7 == 7'h20);
                    dec.imm = imm_sh;
                end else begin
                    dec.imm = imm_i;
                end
            end
            OPC_LUI: begin
                dec.src_a_sel = SRC_A_ZERO;
                dec.src_b_sel = SRC_B_IMM;
                dec.imm       = imm_u;
                writes_rd     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = SRC_B_IMM;
                dec.imm       = imm_u;
                writes_rd     = 1'b1;
            end
            OPC_JAL: begin
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = SRC_B_FOUR;
                dec.imm       = imm_j;
                writes_rd     = 1'b1;
            end
            OPC_JALR: begin
                legal         = (funct3 == 3'b000);
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = SRC_B_FOUR;
                dec.imm       = imm_i;
                writes_rd     = 1'b1;
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1;
                dec.imm       = imm_b;
                case (funct3[2:1])
                    2'b00:   dec.alu_ctl = ALU_SUB;
                    2'b10:   dec.alu_ctl = ALU_SLT;
                    2'b11:   dec.alu_ctl = ALU_SLTU;
                    default: legal       = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.src_b_sel = SRC_B_IMM;
                dec.imm       = imm_i;
                writes_rd     = 1'b1;
            end
            OPC_STORE: begin
                dec.src_b_sel = SRC_B_IMM;
                dec.imm       = imm_s;
            end
            default: legal = 1'b0;
        endcase

        dec.wen = writes_rd && (dec.rd != 5'd0);

        // An illegal bundle still carries its PC and raw register fields for the trap path.
        if (!legal) begin
            dec.alu_ctl   = ALU_ADD;
            dec.src_a_sel = '0;
            dec.src_b_sel = '0;
            dec.imm       = '0;
            dec.wen       = 1'b0;
            dec.is_branch = 1'b0;
        end
        dec.illegal = !legal;
    end

    bundle_t out_q;
    logic    valid_q;
    logic    in_fire;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (in_fire) begin
            valid_q <= 1'b1;
            out_q   <= dec;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_pc    = out_q.pc;
    assign bus.alu_ctl   = out_q.alu_ctl;
    assign bus.src_a_sel = out_q.src_a_sel;
    assign bus.src_b_sel = out_q.src_b_sel;
    assign bus.imm       = out_q.imm;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.wen       = out_q.wen;
    assign bus.is_branch = out_q.is_branch;
    assign bus.illegal   = out_q.illegal;

`ifdef IDU_PERF_CNT_EN
    logic count_en;

    assign count_en = in_fire && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else if (count_en) begin
            perf_decoded <= perf_decoded + 32'd1;
            if (dec.illegal) begin
                perf_illegal <= perf_illegal + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_idu_alu_decode.sv
// Scoreboard bench for idu_alu_decode: directed RV32I vectors streamed with
// back-pressure, plus flush, async reset and illegal-encoding scenarios.
module tb_idu_alu_decode;

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  ctl;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        br;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    idu_alu_decode_if #(.XLEN(32), .CTL_W(4)) bus ();

`ifdef IDU_PERF_CNT_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_illegal;
`endif

    idu_alu_decode #(.XLEN(32), .CTL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IDU_PERF_CNT_EN
        ,
        .perf_decoded (perf_decoded),
        .perf_illegal (perf_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    vec_t vecs[$];
    logic [89:0] sb_q[$];
    int          sb_tag[$];

    task automatic add_vec(input logic [31:0] inst, input logic [3:0] ctl,
                           input logic [1:0] a_sel, input logic [1:0] b_sel,
                           input logic [31:0] imm, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic wen, input logic br, input logic ill);
        vec_t v;
        v = '{inst, ctl, a_sel, b_sel, imm, rs1, rs2, rd, wen, br, ill};
        vecs.push_back(v);
    endtask

    function automatic logic [89:0] observed();
        return {bus.out_pc, bus.alu_ctl, bus.src_a_sel, bus.src_b_sel, bus.imm,
                bus.rs1, bus.rs2, bus.rd, bus.wen, bus.is_branch, bus.illegal};
    endfunction

    function automatic logic [89:0] expected(input vec_t v, input logic [31:0] pc);
        return {pc, v.ctl, v.a_sel, v.b_sel, v.imm, v.rs1, v.rs2, v.rd, v.wen, v.br, v.ill};
    endfunction

    function automatic logic [31:0] pc_of(input int idx);
        return 32'h0000_1000 + 32'(idx) * 32'd4;
    endfunction

    initial begin
        int   idx;
        int   n;
        bit   prev_stall;
        bit   done;
        logic [89:0] held;

        n_checks = 0;
        n_fail   = 0;

        //        inst          ctl    a      b      imm           rs1 rs2 rd  wen br ill
        add_vec(32'h002081B3, 4'h0, 2'd0, 2'd0, 32'h00000000, 1,  2,  3,  1, 0, 0); // add
        add_vec(32'h407302B3, 4'h8, 2'd0, 2'd0, 32'h00000000, 6,  7,  5,  1, 0, 0); // sub
        add_vec(32'h4030D093, 4'hD, 2'd0, 2'd1, 32'h00000003, 1,  3,  1,  1, 0, 0); // srai
        add_vec(32'hFFF00093, 4'h0, 2'd0, 2'd1, 32'hFFFFFFFF, 0,  31, 1,  1, 0, 0); // addi -1
        add_vec(32'hFE208EE3, 4'h8, 2'd0, 2'd0, 32'hFFFFFFFC, 1,  2,  29, 0, 1, 0); // beq -4
        add_vec(32'h00000000, 4'h0, 2'd0, 2'd0, 32'h00000000, 0,  0,  0,  0, 0, 1); // all zero
        add_vec(32'h123452B7, 4'h0, 2'd2, 2'd1, 32'h12345000, 8,  3,  5,  1, 0, 0); // lui
        add_vec(32'h00001017, 4'h0, 2'd1, 2'd1, 32'h00001000, 0,  0,  0,  0, 0, 0); // auipc x0
        add_vec(32'h008000EF, 4'h0, 2'd1, 2'd2, 32'h00000008, 0,  8,  1,  1, 0, 0); // jal +8
        add_vec(32'h004100E7, 4'h0, 2'd1, 2'd2, 32'h00000004, 2,  4,  1,  1, 0, 0); // jalr
        add_vec(32'h004110E7, 4'h0, 2'd0, 2'd0, 32'h00000000, 2,  4,  1,  0, 0, 1); // jalr f3=1
        add_vec(32'h0020A063, 4'h0, 2'd0, 2'd0, 32'h00000000, 1,  2,  0,  0, 0, 1); // branch f3=2
        add_vec(32'h0020E863, 4'h3, 2'd0, 2'd0, 32'h00000010, 1,  2,  16, 0, 1, 0); // bltu +16
        add_vec(32'hFF81A203, 4'h0, 2'd0, 2'd1, 32'hFFFFFFF8, 3,  24, 4,  1, 0, 0); // lw -8
        add_vec(32'h00532623, 4'h0, 2'd0, 2'd1, 32'h0000000C, 6,  5,  12, 0, 0, 0); // sw 12
        add_vec(32'h40209033, 4'h0, 2'd0, 2'd0, 32'h00000000, 1,  2,  0,  0, 0, 1); // sll f7=20
        add_vec(32'h40109093, 4'h0, 2'd0, 2'd0, 32'h00000000, 1,  1,  1,  0, 0, 1); // slli f7=20
        add_vec(32'hFFF1B113, 4'h3, 2'd0, 2'd1, 32'hFFFFFFFF, 3,  31, 2,  1, 0, 0); // sltiu
        add_vec(32'h003150B3, 4'h5, 2'd0, 2'd0, 32'h00000000, 2,  3,  1,  1, 0, 0); // srl
        add_vec(32'h0000000F, 4'h0, 2'd0, 2'd0, 32'h00000000, 0,  0,  0,  0, 0, 1); // fence
        add_vec(32'h0020C033, 4'h4, 2'd0, 2'd0, 32'h00000000, 1,  2,  0,  0, 0, 0); // xor x0
        n = vecs.size();

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_bundle", observed(), 90'd0);
        rst_n = 1'b1;

        // Streaming phase: a fixed 3-cycle stall then a window of random back-pressure.
        idx        = 0;
        prev_stall = 1'b0;
        done       = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 4 && cyc <= 6) &&
                            (cyc < 10 || cyc > 30 || $urandom_range(2, 0) != 0);
            if (idx < n) begin
                bus.in_valid = 1'b1;
                bus.in_inst  = vecs[idx].inst;
                bus.in_pc    = pc_of(idx);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (prev_stall) check("hold_stable", {bus.out_valid, observed()}, {1'b1, held});
            if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("extra_output", 1'b1, 1'b0);
                end else begin
                    check($sformatf("vec%0d", sb_tag.pop_front()), observed(), sb_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = observed();
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(expected(vecs[idx], pc_of(idx)));
                sb_tag.push_back(idx);
                idx++;
            end
            if (idx == n && sb_q.size() == 0) done = 1'b1;
        end
        check("stream_all_sent", idx, n);
        check("stream_none_pending", sb_q.size(), 0);

        // Flush with a simultaneous input transfer: nothing may come out.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h002081B3;
        bus.in_pc     = 32'h0000_2000;
        @(negedge clk);
        check("flush_setup_valid", bus.out_valid, 1'b1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_inst   = 32'h407302B3;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_kills_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check("flush_nothing_emitted", bus.out_valid, 1'b0);

        // Asynchronous reset in the middle of a held bundle.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'hFE208EE3;
        bus.in_pc     = 32'h0000_3000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rst_setup_valid", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_bundle", observed(), 90'd0);
        check("async_rst_in_ready", bus.in_ready, 1'b1);
`ifdef IDU_PERF_CNT_EN
        check("async_rst_perf_decoded", perf_decoded, 32'd0);
        check("async_rst_perf_illegal", perf_illegal, 32'd0);
`endif
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_nothing_emitted", bus.out_valid, 1'b0);

        // A lone all-zero word after reset: illegal bundle, still handshaken.
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00000000;
        bus.in_pc    = 32'h0000_4000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("illegal_zero", {bus.out_valid, observed()}, {1'b1, expected(vecs[5], 32'h0000_4000)});
`ifdef IDU_PERF_CNT_EN
        check("perf_decoded", perf_decoded, 32'd1);
        check("perf_illegal", perf_illegal, 32'd1);
`endif
        @(negedge clk);
        check("drain_drops_valid", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idu_alu_decode.md
Name: idu_alu_decode

Overview:
- Decode-side producer of the 4-bit ALU control code, operand selects and immediates for the RV32I core.
- Sits between fetch and execute.
- Takes one 32-bit instruction plus its PC per handshake and presents a registered decode bundle to the execute stage through a one-entry pipeline register with valid/ready on both sides.
- Full throughput: one instruction per cycle when not back-pressured.

Parameters:
- XLEN, 32, datapath width of PC and immediate.
- CTL_W, 4, ALU control width; encoding is fixed as below.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decoder can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  kill registered and incoming instruction
- out_valid  out  1  decode bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  registered PC
- alu_ctl  out  CTL_W  ALU control code
- src_a_sel  out  2  00 rs1, 01 pc, 10 zero
- src_b_sel  out  2  00 rs2, 01 imm, 10 constant 4
- imm  out  XLEN  sign-extended immediate
- rs1, rs2, rd  out  5 each  register indices
- wen  out  1  writes rd
- is_branch  out  1  conditional branch
- illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n low): all outputs and registers are 0; out_valid=0.
- in_ready = !out_valid || out_ready. Combinational; no other input feeds it.
- Transfer: occurs when in_valid && in_ready. Bundle is registered and out_valid=1 the next cycle (latency 1).
- Hold: while out_valid && !out_ready, all outputs hold stable.
- Simultaneous drain and fill: new bundle replaces old, out_valid stays 1.
- Drain without fill: out_valid drops next cycle.
- flush=1: out_valid=0 next cycle; any simultaneous input transfer is discarded. Flush has priority over all else.
- rst_n deasserted mid-transfer: any in-flight bundle is lost. No output glitch beyond the async clear.
- alu_ctl encoding: bit3 = sub/arith, bits2:0 = funct3-style.
  - 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- OP (0110011): alu_ctl = {funct7[5], funct3}, src 00/00.
  - Legal only if funct7 == 0x00, or funct7 == 0x20 with funct3 in {000, 101}.
- OP-IMM (0010011): alu_ctl = {funct3==101 ? funct7[5] : 0, funct3}, src_b imm.
  - Shifts: imm = zero-extended shamt; funct7 must be 0x00 or 0x20 (0x20 only with 101).
- LUI: add, src_a zero, src_b imm, imm = inst[31:12]<<12.
- AUIPC: add, src_a pc, src_b imm.
- JAL, JALR: add, src_a pc, src_b 4, wen=1.
  - imm = J-type or I-type respectively. JALR requires funct3=000.
- Branch: is_branch=1, wen=0, imm = B-type, src 00/00.
  - beq/bne → 1000; blt/bge → 0010; bltu/bgeu → 0011.
  - funct3 010/011 is illegal.
- LOAD/STORE: add, src_a rs1, src_b imm (I-type/S-type).
  - Loads wen=1; stores wen=0.
- wen=0 whenever rd=0.
- Any other opcode, or an illegal field combination: illegal=1, alu_ctl=0000, wen=0, is_branch=0, src selects 00, imm=0. Still handshaken as a normal bundle.
- rs1/rs2/rd always carry raw instruction fields.

Optional Feature:
- Macro: IDU_PERF_CNT_EN
- When defined:
  - Adds outputs perf_decoded (32) and perf_illegal (32).
  - perf_decoded increments on each input transfer that is not flushed.
  - perf_illegal increments on the same condition when the decoded instruction is illegal.
  - Both counters reset to 0 on rst_n and wrap at 2^32.
- When undefined: no counters and no extra ports.

Test Plan:
- 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, alu_ctl=0000, rd=3, rs1=1, rs2=2, src_b_sel=00, wen=1.
- 0x407302B3 (sub x5,x6,x7) → alu_ctl=1000. 0x4030D093 (srai x1,x1,3) → alu_ctl=1101, imm=0x00000003. 0xFFF00093 (addi x1,x0,-1) → alu_ctl=0000, imm=0xFFFFFFFF.
- 0xFE208EE3 (beq x1,x2,-4) → is_branch=1, alu_ctl=1000, imm=0xFFFFFFFC, wen=0.
- Back-to-back stream with out_ready low for 3 cycles → in_ready=0 during the stall, bundle held bit-stable, no instruction lost or duplicated after release.
- 0x00000000 → illegal=1, wen=0. With IDU_PERF_CNT_EN, perf_illegal=1 and perf_decoded=1.
- flush together with in_valid, and rst_n low while out_valid=1 → out_valid=0 after the edge (async for reset), nothing emitted.
